// File: rtl/truth_table_engine.sv
// Double-buffered, programmable truth-table evaluator with ready/valid input and output streams.
// Software loads a shadow bank via WRITE/CLEAR commands and swaps it in with COMMIT.
module truth_table_engine #(
  parameter int unsigned      N_IN        = 3,
  parameter int unsigned      N_OUT       = 2,
  parameter logic [N_OUT-1:0] DEFAULT_ROW = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_op,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic             loaded
);

  localparam int unsigned DEPTH = 1 << N_IN;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_COMMIT = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;

  logic [N_OUT-1:0] bank_a [DEPTH];
  logic [N_OUT-1:0] bank_b [DEPTH];

  logic             state;
  logic [N_IN-1:0]  clr_cnt;
  logic             active_sel;
  logic             cfg_fire;
  logic             in_fire;
  logic             shadow_we;
  logic [N_IN-1:0]  shadow_addr;
  logic [N_OUT-1:0] shadow_wdata;
  logic [N_OUT-1:0] active_row;

  assign cfg_ready = (state == ST_IDLE);
  assign in_ready  = !out_valid || out_ready;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    shadow_we    = 1'b0;
    shadow_addr  = cfg_addr;
    shadow_wdata = cfg_data;
    if (state == ST_CLEAR) begin
      shadow_we    = 1'b1;
      shadow_addr  = clr_cnt;
      shadow_wdata = DEFAULT_ROW;
    end else if (cfg_fire && (cfg_op == OP_WRITE)) begin
      shadow_we = 1'b1;
    end
  end

  // Only the shadow bank is ever written, so evaluation never sees a partial update.
  always_ff @(posedge clk) begin
    if (shadow_we) begin
      if (active_sel) begin
        bank_a[shadow_addr] <= shadow_wdata;
      end else begin
        bank_b[shadow_addr] <= shadow_wdata;
      end
    end
  end

  assign active_row = active_sel ? bank_b[in_vec] : bank_a[in_vec];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      active_sel <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            case (cfg_op)
              OP_COMMIT: begin
                active_sel <= ~active_sel;
                loaded     <= 1'b1;
              end
              OP_CLEAR: begin
                state   <= ST_CLEAR;
                clr_cnt <= '0;
              end
              default: ;
            endcase
          end
        end
        default: begin
          // Counter wraps back to zero on the final row.
          clr_cnt <= clr_cnt + N_IN'(1);
          if (&clr_cnt) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lookup uses the bank selected before any same-cycle COMMIT takes effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= DEFAULT_ROW;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= loaded ? active_row : DEFAULT_ROW;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench for truth_table_engine: directed scenarios plus randomized traffic
// checked against a table-level model (two tables, a swap flag and a one-deep output slot).
module tb_truth_table_engine;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 2;
  localparam logic [1:0]  DEF   = 2'b10;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic [N_IN-1:0]  cfg_addr;
  logic [N_OUT-1:0] cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic             loaded;

  truth_table_engine #(
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .DEFAULT_ROW(DEF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_op   (cfg_op),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tbl[m_act] is the active table, tbl[1-m_act] the shadow.
  logic [1:0] tbl [2][8];
  int         m_act      = 0;
  bit         m_loaded   = 0;
  int         m_clr_left = 0;
  logic       exp_valid  = 1'b0;
  logic [1:0] exp_data   = DEF;
  logic [1:0] ref_rows [8];

  task automatic step();
    #1;
    if (!rst_n) begin
      exp_valid  = 1'b0;
      exp_data   = DEF;
      m_loaded   = 0;
      m_act      = 0;
      m_clr_left = 0;
    end else begin
      if (in_valid && (!exp_valid || out_ready)) begin
        exp_data  = m_loaded ? tbl[m_act][in_vec] : DEF;
        exp_valid = 1'b1;
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      if (m_clr_left > 0) begin
        m_clr_left--;
      end else if (cfg_valid) begin
        case (cfg_op)
          2'd0: tbl[1-m_act][cfg_addr] = cfg_data;
          2'd1: begin
            m_act    = 1 - m_act;
            m_loaded = 1;
          end
          2'd2: begin
            for (int i = 0; i < 8; i++) tbl[1-m_act][i] = DEF;
            m_clr_left = 8;
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    cfg_op    = 2'd0;
    cfg_addr  = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (out_data !== DEF) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, DEF); end
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 3'd5;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL default_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== DEF) begin errors++; $display("FAIL default_row: got %h want %h", out_data, DEF); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL default_loaded: got %b want 0", loaded); end
    step();
  endtask

  task automatic test_ref_function();
    cfg_valid = 1'b1;
    cfg_op    = 2'd0;
    for (int i = 0; i < 8; i++) begin
      cfg_addr = 3'(i);
      cfg_data = ref_rows[i];
      step();
    end
    cfg_op = 2'd1;
    step();
    cfg_valid = 1'b0;
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL commit_loaded: got %b want 1", loaded); end
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vec = 3'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ref_rows[i]) begin
        errors++;
        $display("FAIL ref_sweep[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, ref_rows[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [2:0] v0, v1;
    v0 = 3'($urandom_range(0, 7));
    v1 = 3'($urandom_range(0, 7));
    in_valid  = 1'b1;
    in_vec    = v0;
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== ref_rows[v0]) begin errors++; $display("FAIL bp_first: got %h want %h", out_data, ref_rows[v0]); end
    out_ready = 1'b0;
    in_vec    = v1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ref_rows[v0]) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h want valid=1 data=%h",
                 c, out_valid, out_data, ref_rows[v0]);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== ref_rows[v1]) begin
      errors++;
      $display("FAIL bp_release: got valid=%b data=%h want valid=1 data=%h",
               out_valid, out_data, ref_rows[v1]);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_shadow_isolation();
    logic [2:0] vk, vk1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cfg_valid = 1'b1;
    cfg_op    = 2'd0;
    cfg_data  = 2'b11;
    for (int i = 0; i < 8; i++) begin
      cfg_addr = 3'(i);
      in_vec   = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (out_data !== ref_rows[in_vec]) begin
        errors++;
        $display("FAIL shadow_iso[%0d]: got %h want %h", i, out_data, ref_rows[in_vec]);
      end
    end
    vk     = 3'($urandom_range(0, 7));
    vk1    = 3'($urandom_range(0, 7));
    cfg_op = 2'd1;
    in_vec = vk;
    step();
    checks++; if (out_data !== ref_rows[vk]) begin errors++; $display("FAIL commit_same_cycle: got %h want %h", out_data, ref_rows[vk]); end
    cfg_valid = 1'b0;
    in_vec    = vk1;
    step();
    checks++; if (out_data !== 2'b11) begin errors++; $display("FAIL commit_next_cycle: got %h want 3", out_data); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_clear();
    logic [1:0] want;
    cfg_valid = 1'b1;
    cfg_op    = 2'd2;
    step();
    // A WRITE held pending across the whole CLEAR must land only once CLEAR finishes.
    cfg_op   = 2'd0;
    cfg_addr = 3'd3;
    cfg_data = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL clear_busy[%0d]: got %b want 0", c, cfg_ready); end
      in_valid = 1'($urandom_range(0, 1));
      in_vec   = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin
        errors++;
        $display("FAIL clear_eval[%0d]: got valid=%b data=%h want valid=%b data=%h",
                 c, out_valid, out_data, exp_valid, exp_data);
      end
    end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL clear_done: got %b want 1", cfg_ready); end
    in_valid = 1'b0;
    step();
    cfg_op = 2'd1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_vec = 3'(i);
      step();
      want = (i == 3) ? 2'b01 : DEF;
      checks++; if (out_data !== want) begin errors++; $display("FAIL clear_sweep[%0d]: got %h want %h", i, out_data, want); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      r         = $urandom_range(0, 15);
      cfg_op    = (r < 10) ? 2'd0 : (r < 12) ? 2'd1 : (r < 13) ? 2'd2 : 2'd3;
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin
        errors++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h want valid=%b data=%h",
                 c, out_valid, out_data, exp_valid, exp_data);
      end
      checks++;
      if (loaded !== m_loaded || cfg_ready !== (m_clr_left == 0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got loaded=%b cfg_ready=%b want loaded=%b cfg_ready=%b",
                 c, loaded, cfg_ready, m_loaded, (m_clr_left == 0));
      end
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) step();
  endtask

  task automatic test_reset_mid();
    in_valid  = 1'b1;
    in_vec    = 3'($urandom_range(0, 7));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cfg_valid = 1'b1;
    cfg_op    = 2'd2;
    step();
    cfg_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_setup: got valid=%b cfg_ready=%b want 1 0", out_valid, cfg_ready); end
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cfg_ready: got %b want 1", cfg_ready); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL mid_rst_loaded: got %b want 0", loaded); end
    checks++; if (out_data !== DEF) begin errors++; $display("FAIL mid_rst_data: got %h want %h", out_data, DEF); end
    rst_n = 1'b1;
    idle_inputs();
    step();
  endtask

  initial begin
    ref_rows = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
    for (int b = 0; b < 2; b++) for (int i = 0; i < 8; i++) tbl[b][i] = 2'bxx;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_ref_function();
    test_backpressure();
    test_shadow_isolation();
    test_clear();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_engine.md
# truth_table_engine

Programmable, pipelined truth-table evaluator: maps an N_IN-bit input vector to an N_OUT-bit output row from a software-loaded table. It generalises the fixed case-statement logic cells in the synthesis flow to arbitrary width and output count. The table is double-buffered, so a new function can be loaded into a shadow bank while the active bank keeps evaluating. It sits between netlist-generated stimulus sources and downstream gate-model consumers, with ready/valid on both sides.

## Interface
- N_IN, 3: input vector width; table depth is 2^N_IN rows.
- N_OUT, 2: output row width.
- DEFAULT_ROW, 0: N_OUT-bit value returned before the first commit.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous and active-low.
- cfg_valid  in  1  configuration command valid.
- cfg_ready  out  1  configuration command accepted when high with cfg_valid.
- cfg_op  in  2  command: 0 WRITE, 1 COMMIT, 2 CLEAR, 3 reserved (accepted, no effect).
- cfg_addr  in  N_IN  shadow row index for WRITE.
- cfg_data  in  N_OUT  row data for WRITE.
- in_valid / in_ready  in / out  1  input handshake.
- in_vec  in  N_IN  input vector; bit 0 is the LSB of the row index.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  N_OUT  evaluated row.
- loaded  out  1  high once at least one COMMIT has completed.

## Operation
- Two banks, A and B, each 2^N_IN × N_OUT. `active_sel` selects the evaluating bank; the other bank is the shadow.
- Config FSM states are IDLE and CLEAR.
  - IDLE: cfg_ready=1.
    - WRITE: writes cfg_data to shadow[cfg_addr].
    - COMMIT: toggles active_sel and sets loaded=1.
    - CLEAR: moves the FSM to CLEAR, with clr_cnt=0.
  - CLEAR: cfg_ready=0. Each cycle writes DEFAULT_ROW to shadow[clr_cnt] and increments clr_cnt. After writing row 2^N_IN−1, returns to IDLE. This takes exactly 2^N_IN cycles, and the counter wraps to 0 on exit.
- Evaluation: on in_valid && in_ready, register out_data = loaded ? active[in_vec] : DEFAULT_ROW and set out_valid=1.
- in_ready = !out_valid || out_ready, so full throughput is one vector per cycle with no bubble.
- out_valid clears on out_ready when no new input is accepted in the same cycle.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous COMMIT and input accept: the lookup uses the pre-commit active bank. The swap takes effect for inputs accepted from the next cycle onward.
- WRITE never alters the active bank, so outputs are unaffected by in-flight configuration.
- After a COMMIT, the former active bank becomes the shadow with its old contents intact. No implicit clear; software issues CLEAR or WRITEs as needed.

## Timing
- Reset (rst_n=0 at a clock edge) forces the following, in the same edge, including mid-CLEAR or mid-stall:
  - out_valid=0, out_data=DEFAULT_ROW, loaded=0, active_sel=0 (bank A active)
  - FSM=IDLE, clr_cnt=0
  - cfg_ready is then 1.
- Bank contents are not reset. Outputs read DEFAULT_ROW until a COMMIT because loaded=0.
- Evaluation latency: 1 cycle from input accept to out_valid.
- COMMIT latency: 1 cycle. loaded rises on the edge that accepts the first COMMIT.
- CLEAR: cfg_ready is low for cycles 1..2^N_IN after acceptance and high again on cycle 2^N_IN+1.
- Evaluation continues unaffected during CLEAR.
- cfg_ready is combinational from the FSM state only. in_ready is combinational from out_valid and out_ready.

## Test plan
- **Reset default:** after reset, send in_vec=5 with out_ready=1 → out_data=DEFAULT_ROW (0) one cycle later; loaded=0.
- **Load and evaluate the 3-input reference function:**
  - Stimulus: WRITE rows {0:0,1:0,2:1,3:1,4:1,5:0,6:0,7:1} (N_OUT=1 build), then COMMIT, then sweep in_vec 0..7 back-to-back.
  - Required: outputs 0,0,1,1,1,0,0,1, one per cycle, with no gaps.
- **Backpressure:** hold out_ready=0 for 4 cycles with an output pending and in_valid=1.
  - Required: in_ready=0 for all 4 cycles; out_data stable.
  - On release: the next vector is evaluated and nothing is dropped or duplicated.
- **Shadow isolation:** with pattern A active, WRITE all-ones into the shadow while streaming inputs.
  - Required: outputs still match A.
  - COMMIT accepted in the same cycle as input k: input k uses A, input k+1 uses the all-ones pattern.
- **CLEAR timing (N_IN=3):** issue CLEAR.
  - Required: cfg_ready=0 for exactly 8 cycles and WRITE stalls during that time.
  - After a COMMIT, every in_vec returns DEFAULT_ROW.
- **Reset mid-operation:** assert rst_n=0 in the 3rd cycle of CLEAR while out_valid=1 and stalled.
  - Required on the next cycle: out_valid=0, cfg_ready=1, loaded=0.
